pipeline_ctrl: RTL
==================

# pipeline_ctrl

Central stall/flush sequencer for the 5-stage RV32I pipeline. It merges three hazard sources into one consistent set of per-stage register enables and flushes:

- the load-use stall request from hazard detection;
- the taken-branch/jump redirect from EX;
- multi-cycle instruction and data memory handshakes.

It also tracks memory-wait timeouts and keeps saturating performance counters. It sits beside the datapath and drives every pipeline register and the PC register.

## Interface
Parameters:
- TIMEOUT, default 255: maximum consecutive data-memory wait cycles before the error state is entered.
- CNT_W, default 32: width of the performance counters.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_ni  input  1  asynchronous active-low reset.
- load_use_i  input  1  load-use stall request (hazard detection ID_EX_flush).
- redirect_EX_i  input  1  branch taken or jump resolved in EX; PC is being redirected.
- imem_ready_i  input  1  instruction memory has the fetch word this cycle.
- dmem_req_MEM_i  input  1  load/store present in MEM.
- dmem_ready_i  input  1  data memory completes the MEM access this cycle.
- pc_en_o  output  1  PC register enable.
- IF_ID_en_o, ID_EX_en_o, EX_MEM_en_o, MEM_WB_en_o  output  1 each  pipeline register enables.
- IF_ID_flush_o, ID_EX_flush_o, MEM_WB_flush_o  output  1 each  load a bubble (NOP, all control zero) on the next edge.
- err_o  output  1  sticky data-memory timeout error.
- stall_cnt_o  output  CNT_W  cycles in which pc_en_o = 0.
- flush_cnt_o  output  CNT_W  number of redirect flushes applied.

## Operation
FSM states:
- RUN
- DWAIT: data memory outstanding.
- ERR

Transitions:
- RUN -> DWAIT when dmem_req_MEM_i & ~dmem_ready_i.
- DWAIT -> RUN when dmem_ready_i.
- DWAIT -> ERR when the wait counter equals TIMEOUT-1 and ~dmem_ready_i.
- ERR is left only by reset.

Wait counter:
- Cleared in RUN.
- Incremented each DWAIT cycle.
- Width is clog2(TIMEOUT+1).

Priority of stall/flush decisions, highest first:
1. ERR: all enables 0, all flushes 0. Pipeline frozen.
2. dstall = dmem_req_MEM_i & ~dmem_ready_i (any state except ERR):
   - pc_en_o, IF_ID_en_o, ID_EX_en_o, EX_MEM_en_o = 0.
   - MEM_WB_flush_o = 1.
   - Every other flush is 0. A concurrent redirect_EX_i is held, not applied; EX is frozen, so it re-presents after the stall.
3. redirect_EX_i:
   - IF_ID_flush_o = ID_EX_flush_o = 1.
   - All enables 1, including pc_en_o, so the redirect target loads.
   - load_use_i and imem_ready_i are ignored this cycle.
4. load_use_i:
   - pc_en_o = IF_ID_en_o = 0.
   - ID_EX_flush_o = 1.
   - Downstream enables are 1.
5. ~imem_ready_i:
   - pc_en_o = 0.
   - IF_ID_flush_o = 1.
   - All downstream enables are 1.
6. Otherwise: all enables 1, all flushes 0.

General rules:
- A flush overrides the corresponding enable inside the pipeline register. When a flush is asserted, this block also drives that register's enable to 1.
- stall_cnt_o increments on each edge where pc_en_o = 0. This includes ERR cycles.
- flush_cnt_o increments on each edge where priority-3 applies.
- Both counters saturate at 2^CNT_W-1; they do not wrap.

## Timing
- All enables and flushes are combinational from inputs and state; there is zero-cycle latency from a request to its control outputs.
- err_o is registered. It asserts on the edge following the TIMEOUT-th consecutive wait cycle.
- Counters are registered and show the count one edge after the qualifying cycle.
- Reset values:
  - state = RUN, wait counter = 0, err_o = 0, stall_cnt_o = 0, flush_cnt_o = 0.
  - During reset the combinational outputs follow RUN decoding.
- Reset asserted mid-DWAIT or in ERR returns the block to RUN immediately; a partial wait count is discarded.
- dmem_ready_i in the same cycle as DWAIT entry conditions means no stall and no state change.
- Simultaneous load_use_i and redirect_EX_i: the redirect wins, because the stalled ID instruction is squashed anyway.

## Structure
- Shared pipeline package holds the FSM state enum (RUN, DWAIT, ERR) and the bubble/NOP encoding 32'h0000_0013 used by pipeline registers on flush.
- Natural sub-module: sat_counter (parameterised width, inc enable, saturating). Instantiated twice.

## Test plan
- load_use_i=1 for one cycle, other inputs idle -> pc_en_o=0, IF_ID_en_o=0, ID_EX_flush_o=1; stall_cnt_o=1 next cycle.
- redirect_EX_i=1 with load_use_i=1 -> IF_ID_flush_o=ID_EX_flush_o=1, pc_en_o=1; flush_cnt_o=1 next cycle.
- dmem_req_MEM_i=1, dmem_ready_i=0 for 3 cycles then 1, redirect_EX_i=1 throughout:
  - 3 cycles of full freeze with MEM_WB_flush_o=1 and no IF/ID flush;
  - then the redirect applies in cycle 4;
  - stall_cnt_o=3.
- TIMEOUT=4, dmem_ready_i held 0 -> err_o=1 after 4 wait cycles; all enables 0 thereafter, even when dmem_ready_i later rises.
- Reset pulse while in ERR with stall_cnt_o=10 -> err_o=0, counters 0, RUN decoding immediately.
- CNT_W=4, load_use_i held 20 cycles -> stall_cnt_o stops at 15.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// Shared pipeline definitions: sequencer FSM states and the bubble instruction
// that pipeline registers load when flushed.
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DWAIT = 2'd1,
    ERR   = 2'd2
  } state_e;

  localparam logic [31:0] NOP_INSN = 32'h0000_0013;  // addi x0, x0, 0

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Hazard requests into the stall/flush sequencer and the per-stage enables
// and flushes it drives back into the datapath.
interface pipeline_ctrl_if;

  logic load_use_i;
  logic redirect_EX_i;
  logic imem_ready_i;
  logic dmem_req_MEM_i;
  logic dmem_ready_i;

  logic pc_en_o;
  logic IF_ID_en_o;
  logic ID_EX_en_o;
  logic EX_MEM_en_o;
  logic MEM_WB_en_o;
  logic IF_ID_flush_o;
  logic ID_EX_flush_o;
  logic MEM_WB_flush_o;

  // master: datapath/hazard side; slave: the sequencer itself
  modport master (
    output load_use_i, redirect_EX_i, imem_ready_i, dmem_req_MEM_i, dmem_ready_i,
    input  pc_en_o, IF_ID_en_o, ID_EX_en_o, EX_MEM_en_o, MEM_WB_en_o,
    input  IF_ID_flush_o, ID_EX_flush_o, MEM_WB_flush_o
  );

  modport slave (
    input  load_use_i, redirect_EX_i, imem_ready_i, dmem_req_MEM_i, dmem_ready_i,
    output pc_en_o, IF_ID_en_o, ID_EX_en_o, EX_MEM_en_o, MEM_WB_en_o,
    output IF_ID_flush_o, ID_EX_flush_o, MEM_WB_flush_o
  );

endinterface

// File: rtl/pipeline_ctrl_sat_counter.sv
// Event counter that sticks at its maximum value instead of wrapping.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_reg;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_reg <= '0;
    end else if (inc_i && !(&cnt_reg)) begin
      cnt_reg <= cnt_reg + W'(1);
    end
  end

  assign cnt_o = cnt_reg;

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer: merges data-memory waits, EX redirects, load-use
// stalls and fetch waits into one set of pipeline register controls.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  pipeline_ctrl_if.slave   bus,
  output logic             err_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  localparam int WAIT_W = $clog2(TIMEOUT + 1);

  state_e            state_reg, state_next;
  logic [WAIT_W-1:0] wait_reg,  wait_next;
  logic              err_reg;
  logic              dstall;
  logic              redirect_apply;

  assign dstall = bus.dmem_req_MEM_i && !bus.dmem_ready_i;

  always_comb begin
    state_next         = state_reg;
    wait_next          = '0;
    redirect_apply     = 1'b0;
    bus.pc_en_o        = 1'b1;
    bus.IF_ID_en_o     = 1'b1;
    bus.ID_EX_en_o     = 1'b1;
    bus.EX_MEM_en_o    = 1'b1;
    bus.MEM_WB_en_o    = 1'b1;
    bus.IF_ID_flush_o  = 1'b0;
    bus.ID_EX_flush_o  = 1'b0;
    bus.MEM_WB_flush_o = 1'b0;

    case (state_reg)
      RUN:     if (dstall) state_next = DWAIT;
      DWAIT: begin
        wait_next = wait_reg + WAIT_W'(1);
        if (bus.dmem_ready_i)                      state_next = RUN;
        else if (wait_reg == WAIT_W'(TIMEOUT - 1)) state_next = ERR;
      end
      default: state_next = ERR;
    endcase

    if (state_reg == ERR) begin
      bus.pc_en_o     = 1'b0;
      bus.IF_ID_en_o  = 1'b0;
      bus.ID_EX_en_o  = 1'b0;
      bus.EX_MEM_en_o = 1'b0;
      bus.MEM_WB_en_o = 1'b0;
    end else if (dstall) begin
      // EX stays frozen, so a pending redirect re-presents once memory completes
      bus.pc_en_o        = 1'b0;
      bus.IF_ID_en_o     = 1'b0;
      bus.ID_EX_en_o     = 1'b0;
      bus.EX_MEM_en_o    = 1'b0;
      bus.MEM_WB_flush_o = 1'b1;
    end else if (bus.redirect_EX_i) begin
      redirect_apply    = 1'b1;
      bus.IF_ID_flush_o = 1'b1;
      bus.ID_EX_flush_o = 1'b1;
    end else if (bus.load_use_i) begin
      bus.pc_en_o       = 1'b0;
      bus.IF_ID_en_o    = 1'b0;
      bus.ID_EX_flush_o = 1'b1;
    end else if (!bus.imem_ready_i) begin
      bus.pc_en_o       = 1'b0;
      bus.IF_ID_flush_o = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg <= RUN;
      wait_reg  <= '0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      wait_reg  <= wait_next;
      err_reg   <= (state_next == ERR);
    end
  end

  assign err_o = err_reg;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .inc_i  (!bus.pc_en_o),
    .cnt_o  (stall_cnt_o)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .inc_i  (redirect_apply),
    .cnt_o  (flush_cnt_o)
  );

endmodule
